// File: rtl/mining_pkg.sv
// Shared types and constants for the double-SHA256 mining sequencer.
package mining_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 256;

    localparam logic PASS_FIRST  = 1'b0;
    localparam logic PASS_SECOND = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_P1_ISSUE,
        S_P1_WAIT,
        S_P2_ISSUE,
        S_P2_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUST
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == S_LOAD) || (s == S_P1_ISSUE) || (s == S_P1_WAIT) ||
               (s == S_P2_ISSUE) || (s == S_P2_WAIT) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/mining_ctrl_cmp.sv
// Leading-zero target compare: the top `difficulty` bits of the digest must be zero.
module hash_target_cmp #(
    parameter int HASH_W = 256
) (
    input  logic [HASH_W-1:0] digest,
    input  logic [7:0]        difficulty,
    output logic              match
);

    logic [HASH_W-1:0] mask;

    // Difficulty 0 gives an empty mask, so every digest matches.
    always_comb begin
        mask  = ~({HASH_W{1'b1}} >> difficulty);
        match = ((digest & mask) == '0);
    end

endmodule

// File: rtl/mining_ctrl.sv
// Nonce-walking sequencer driving two hash-core passes per nonce.
// Optional per-pass watchdog enabled by defining MINING_CTRL_TIMEOUT_EN.
module mining_ctrl
    import mining_pkg::*;
#(
    parameter int NONCE_W        = NONCE_W_DEF,
    parameter int HASH_W         = HASH_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_pulse,
    input  logic               stop_pulse,
    input  logic [7:0]         difficulty,
    input  logic [NONCE_W-1:0] nonce_start,
    output logic               core_start,
    output logic               core_pass,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] hash_count
);

    state_t            state;
    state_t            state_next;
    logic [HASH_W-1:0] hash_q;
    logic              match;
    logic              timeout_hit;

    hash_target_cmp #(.HASH_W(HASH_W)) u_cmp (
        .digest     (hash_q),
        .difficulty (difficulty),
        .match      (match)
    );

`ifdef MINING_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
    logic            in_wait;

    assign in_wait     = (state == S_P1_WAIT) || (state == S_P2_WAIT);
    assign timeout_hit = in_wait && !core_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    // Counter only advances while waiting, so each ISSUE restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
            if (state == S_LOAD)
                timeout_q <= 1'b0;
            else if (timeout_hit && !stop_pulse)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // stop_pulse wins over everything while busy; key_pulse never restarts a busy run.
    always_comb begin
        state_next = state;
        if (stop_pulse && is_busy(state)) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (key_pulse && !stop_pulse) state_next = S_LOAD;
                S_LOAD:     state_next = S_P1_ISSUE;
                S_P1_ISSUE: state_next = S_P1_WAIT;
                S_P1_WAIT: begin
                    if (core_done)        state_next = S_P2_ISSUE;
                    else if (timeout_hit) state_next = S_IDLE;
                end
                S_P2_ISSUE: state_next = S_P2_WAIT;
                S_P2_WAIT: begin
                    if (core_done)        state_next = S_CHECK;
                    else if (timeout_hit) state_next = S_IDLE;
                end
                S_CHECK: begin
                    if (match)       state_next = S_FOUND;
                    else if (&nonce) state_next = S_EXHAUST;
                    else             state_next = S_P1_ISSUE;
                end
                S_FOUND, S_EXHAUST: if (key_pulse && !stop_pulse) state_next = S_LOAD;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            nonce      <= '0;
            hash_count <= '0;
            hash_q     <= '0;
            core_start <= 1'b0;
            core_pass  <= PASS_FIRST;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
        end else begin
            state      <= state_next;
            core_start <= (state_next == S_P1_ISSUE) || (state_next == S_P2_ISSUE);
            core_pass  <= ((state_next == S_P2_ISSUE) || (state_next == S_P2_WAIT)) ?
                          PASS_SECOND : PASS_FIRST;
            busy       <= is_busy(state_next);
            found      <= (state_next == S_FOUND);
            exhausted  <= (state_next == S_EXHAUST);

            if (state == S_LOAD && state_next == S_P1_ISSUE) begin
                nonce      <= nonce_start;
                hash_count <= '0;
            end

            if (state == S_P2_WAIT && state_next == S_CHECK)
                hash_q <= core_hash;

            if (state == S_CHECK && state_next != S_IDLE) begin
                if (!(&hash_count))
                    hash_count <= hash_count + 1'b1;
                if (state_next == S_P1_ISSUE)
                    nonce <= nonce + 1'b1;
            end
        end
    end

endmodule
